// File: rtl/irq_arbiter.sv
// irq_arbiter: latches level interrupt sources and presents the best pending/enabled one to the CPU with claim/complete.
module irq_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] i_src_irq,
  input  logic               i_cfg_re,
  input  logic               i_cfg_we,
  input  logic [7:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_wdata,
  output logic [31:0]        o_cfg_rdata,
  output logic               o_ext_irq
);
  logic [PRIO_W-1:0]  r_prio [NUM_SRC];
  logic [NUM_SRC-1:0] r_pend, r_insvc, r_en;
  logic [PRIO_W-1:0]  r_thr;
  logic [5:0]         w_word;
  logic [4:0]         w_win_id, w_cid;
  logic [PRIO_W-1:0]  w_best, w_prio_rd;
  logic [NUM_SRC-1:0] w_clm, w_cmp;
  logic               w_claim, w_comp, w_unused;

  assign w_word   = i_cfg_addr[7:2];
  assign w_cid    = i_cfg_wdata[4:0];
  assign w_claim  = i_cfg_re && w_word == 6'h23;
  assign w_comp   = i_cfg_we && w_word == 6'h23;
  assign w_unused = ^{i_cfg_addr[1:0], i_cfg_wdata};

  // strict '>' keeps the lowest ID on priority ties
  always_comb begin
    w_win_id  = '0;
    w_best    = '0;
    w_prio_rd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_pend[k] && r_en[k] && r_prio[k] > r_thr && r_prio[k] > w_best) begin
        w_best   = r_prio[k];
        w_win_id = 5'(k + 1);
      end
      if (w_word == 6'(k)) w_prio_rd = r_prio[k];
    end
  end

  // a complete naming the ID being claimed in the same cycle is dropped
  always_comb begin
    w_clm = '0;
    w_cmp = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_clm[k] = w_claim && w_win_id == 5'(k + 1);
      w_cmp[k] = w_comp && w_cid == 5'(k + 1) && r_insvc[k] && !(w_claim && w_cid == w_win_id);
    end
  end

  assign o_cfg_rdata = (w_word < 6'(NUM_SRC)) ? 32'(w_prio_rd) :
                       (w_word == 6'h20)      ? 32'(r_pend)    :
                       (w_word == 6'h21)      ? 32'(r_en)      :
                       (w_word == 6'h22)      ? 32'(r_thr)     :
                       (w_word == 6'h23)      ? 32'(w_win_id)  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= '0;
      r_insvc   <= '0;
      r_en      <= '0;
      r_thr     <= '0;
      o_ext_irq <= 1'b0;
      for (int k = 0; k < NUM_SRC; k++) r_prio[k] <= '0;
    end else begin
      r_pend    <= (r_pend | (i_src_irq & ~r_insvc)) & ~w_clm;
      r_insvc   <= (r_insvc | w_clm) & ~w_cmp;
      o_ext_irq <= w_win_id != 5'd0;
      if (i_cfg_we && w_word == 6'h21) r_en <= i_cfg_wdata[NUM_SRC-1:0];
      if (i_cfg_we && w_word == 6'h22) r_thr <= i_cfg_wdata[PRIO_W-1:0];
      for (int k = 0; k < NUM_SRC; k++)
        if (i_cfg_we && w_word == 6'(k)) r_prio[k] <= i_cfg_wdata[PRIO_W-1:0];
    end
  end
endmodule
